apb_master_fsm: RTL
===================

Name: apb_master_fsm

Overview:
APB-side back end of the AXI4-Lite to APB bridge. It takes fully-formed write and read requests from the AXI4-Lite slave front end and runs one APB3/APB4 transfer per request (SETUP → ACCESS). It returns the write response, or the read data and response, through a valid/ready handshake. A bounded-wait timer ends hung APB transfers with an error.

Parameters:
dataWidth, 32, APB/AXI data width in bits; must be a multiple of 8.
addrWidth, 32, address width in bits.
TIMEOUT, 256, maximum ACCESS cycles without pready before a forced error; 0 disables the timer.

Ports:
aclk  input  1  clock, shared with the AXI4-Lite front end.
aresetn  input  1  reset, synchronous, active-low.
wr_valid  input  1  write request present.
wr_ready  output  1  write request accepted.
wr_addr  input  addrWidth  write address.
wr_prot  input  3  write protection attributes.
wr_data  input  dataWidth  write data.
wr_strb  input  dataWidth/8  write byte strobes.
rd_valid  input  1  read request present.
rd_ready  output  1  read request accepted.
rd_addr  input  addrWidth  read address.
rd_prot  input  3  read protection attributes.
b_valid  output  1  write response valid.
b_ready  input  1  write response consumed.
b_resp  output  2  write response code.
r_valid  output  1  read response valid.
r_ready  input  1  read response consumed.
r_data  output  dataWidth  read data.
r_resp  output  2  read response code.
paddr  output  addrWidth  APB address.
psel  output  1  APB select.
penable  output  1  APB enable.
pwrite  output  1  APB direction (1 = write).
pwdata  output  dataWidth  APB write data.
pstrb  output  dataWidth/8  APB write strobes.
pprot  output  3  APB protection attributes.
pready  input  1  APB slave ready.
prdata  input  dataWidth  APB read data.
pslverr  input  1  APB slave error.

Behaviour:
- Clock and reset: one clock, aclk. aresetn is synchronous and active-low; it is sampled only on the rising edge of aclk.
- Reset values: state IDLE; all outputs 0 (psel, penable, pwrite, paddr, pwdata, pstrb, pprot, b_valid, b_resp, r_valid, r_data, r_resp). The timer clears to 0.
- Reset mid-operation: on the next edge, psel and penable drop to 0, any pending response is discarded, and the FSM returns to IDLE.
- Ready signals (combinational from state):
  - wr_ready = (state == IDLE).
  - rd_ready = (state == IDLE) && !wr_valid.
- Arbitration: when wr_valid and rd_valid are both high in IDLE, the write wins and the read waits.
- FSM states:
  - IDLE → SETUP on an accepted request. Capture into registers: paddr, pprot, pwrite, and, for writes, pwdata and pstrb. For reads, pwdata and pstrb are driven 0.
  - SETUP: psel=1, penable=0. Always → ACCESS after 1 cycle.
  - ACCESS: psel=1, penable=1. Outputs are held stable until exit.
    - If pready: → WRESP or RRESP, and psel/penable go to 0 on the same edge. Response = pslverr ? SLVERR (2'b10) : OKAY (2'b00). For reads, r_data <= prdata; on error, r_data still captures prdata.
    - Else if TIMEOUT != 0 and the timer equals TIMEOUT-1: → WRESP or RRESP with DECERR (2'b11), r_data=0, and psel/penable dropped.
    - Else: the timer increments.
  - WRESP: b_valid=1; b_resp is held stable. Leave on b_ready → IDLE, with b_valid=0 on the next cycle.
  - RRESP: r_valid=1; r_data and r_resp are held stable. Leave on r_ready → IDLE.
- Latency: acceptance at edge N gives SETUP at N+1 and ACCESS at N+2. With pready=1 at once, the response is valid at N+3. Minimum request-to-request spacing is 4 cycles (with b_ready/r_ready tied high).
- Timer: width $clog2(TIMEOUT+1). It clears on entry to SETUP. It counts only in ACCESS while pready=0.
- Accept rule: a new request is never accepted while a response is pending; one transfer is outstanding at most.
- pslverr is ignored when pready=0.

Decomposition:
- Package apb_axi_pkg holds:
  - resp_t enum {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11};
  - apb_state_t enum {IDLE, SETUP, ACCESS, WRESP, RRESP}.
- The front end and the bridge top also use apb_axi_pkg.
- Single module; the timer is inline, so no sub-module is needed.

Test Plan:
1. Write, zero wait: wr_addr=0x10, wr_data=0xDEADBEEF, wr_strb=4'hF; pready=1 in the first ACCESS → psel rises at N+1 and penable at N+2. pwdata=0xDEADBEEF, then b_valid at N+3 with b_resp=00.
2. Read with 3 wait states: rd_addr=0x24; pready low 3 ACCESS cycles, then high with prdata=0x12345678 → r_data=0x12345678, r_resp=00, and ACCESS lasts exactly 4 cycles.
3. Simultaneous requests: wr_valid=rd_valid=1 in IDLE → write issued first (pwrite=1) and rd_ready=0. After b handshake, the read is issued.
4. Slave error: read with pready=1 and pslverr=1, prdata=0xA5A5A5A5 → r_resp=10, r_data=0xA5A5A5A5.
5. Timeout: TIMEOUT=8, pready held 0 → after 8 ACCESS cycles, psel=0 and b_resp=11 (write case). A later transfer completes normally.
6. Back-pressure and reset: hold b_ready=0 for 5 cycles → b_valid/b_resp stable and wr_ready=0. Then assert aresetn=0 for 1 clock during ACCESS of the next transfer → all outputs 0 on the following edge and state IDLE.

Source files
------------

// File: rtl/apb_axi_pkg.sv
// Shared types for the AXI4-Lite to APB bridge: response codes and APB master states.
package apb_axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WRESP,
        RRESP
    } apb_state_t;

endpackage

// File: rtl/apb_master_fsm.sv
// APB back end of the AXI4-Lite bridge: runs one SETUP/ACCESS transfer per accepted
// request and returns the response; a bounded-wait timer ends hung transfers with DECERR.
module apb_master_fsm
    import apb_axi_pkg::*;
#(
    parameter int dataWidth = 32,
    parameter int addrWidth = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [addrWidth-1:0]   wr_addr,
    input  logic [2:0]             wr_prot,
    input  logic [dataWidth-1:0]   wr_data,
    input  logic [dataWidth/8-1:0] wr_strb,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic [addrWidth-1:0]   rd_addr,
    input  logic [2:0]             rd_prot,
    output logic                   b_valid,
    input  logic                   b_ready,
    output logic [1:0]             b_resp,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [dataWidth-1:0]   r_data,
    output logic [1:0]             r_resp,
    output logic [addrWidth-1:0]   paddr,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [dataWidth-1:0]   pwdata,
    output logic [dataWidth/8-1:0] pstrb,
    output logic [2:0]             pprot,
    input  logic                   pready,
    input  logic [dataWidth-1:0]   prdata,
    input  logic                   pslverr
);

    localparam int STRB_W = dataWidth / 8;
    localparam int TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    apb_state_t            r_state;
    apb_state_t            w_next;
    logic [TMR_W-1:0]      r_timer;
    logic [addrWidth-1:0]  r_paddr;
    logic [2:0]            r_pprot;
    logic                  r_pwrite;
    logic [dataWidth-1:0]  r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    resp_t                 r_b_resp;
    resp_t                 r_r_resp;
    logic [dataWidth-1:0]  r_r_data;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_tmo;
    logic w_psel;
    logic w_penable;
    logic w_b_valid;
    logic w_r_valid;

    // Write wins arbitration; the read is only offered when no write is pending.
    assign w_wr_acc = (r_state == IDLE) && wr_valid;
    assign w_rd_acc = (r_state == IDLE) && !wr_valid && rd_valid;
    assign w_tmo    = (TIMEOUT != 0) && (r_timer == TMR_LAST);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_psel    = 1'b0;
        w_penable = 1'b0;
        w_b_valid = 1'b0;
        w_r_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_wr_acc || w_rd_acc) w_next = SETUP;
            end
            SETUP: begin
                w_psel = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (pready || w_tmo) w_next = r_pwrite ? WRESP : RRESP;
            end
            WRESP: begin
                w_b_valid = 1'b1;
                if (b_ready) w_next = IDLE;
            end
            RRESP: begin
                w_r_valid = 1'b1;
                if (r_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_timer  <= '0;
            r_paddr  <= '0;
            r_pprot  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_b_resp <= OKAY;
            r_r_resp <= OKAY;
            r_r_data <= '0;
        end else if (w_wr_acc) begin
            r_timer  <= '0;
            r_paddr  <= wr_addr;
            r_pprot  <= wr_prot;
            r_pwrite <= 1'b1;
            r_pwdata <= wr_data;
            r_pstrb  <= wr_strb;
        end else if (w_rd_acc) begin
            r_timer  <= '0;
            r_paddr  <= rd_addr;
            r_pprot  <= rd_prot;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (r_state == ACCESS) begin
            // pslverr only counts on the pready cycle; the timer never preempts a real completion.
            if (pready) begin
                if (r_pwrite) begin
                    r_b_resp <= pslverr ? SLVERR : OKAY;
                end else begin
                    r_r_resp <= pslverr ? SLVERR : OKAY;
                    r_r_data <= prdata;
                end
            end else if (w_tmo) begin
                if (r_pwrite) begin
                    r_b_resp <= DECERR;
                end else begin
                    r_r_resp <= DECERR;
                    r_r_data <= '0;
                end
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    assign wr_ready = (r_state == IDLE);
    assign rd_ready = (r_state == IDLE) && !wr_valid;
    assign psel     = w_psel;
    assign penable  = w_penable;
    assign b_valid  = w_b_valid;
    assign r_valid  = w_r_valid;
    assign paddr    = r_paddr;
    assign pprot    = r_pprot;
    assign pwrite   = r_pwrite;
    assign pwdata   = r_pwdata;
    assign pstrb    = r_pstrb;
    assign b_resp   = r_b_resp;
    assign r_resp   = r_r_resp;
    assign r_data   = r_r_data;

endmodule
